// File: rtl/read_superpixel_if.sv
// Client and RAM-read signals of the superpixel readback block.
// Combinational bundle with no storage and no added latency.
// Requests are accepted only while oready is high; the RAM read port takes no backpressure.
interface read_superpixel_if #(
    parameter int SPIXEL_X_WIDTH = 6,
    parameter int SPIXEL_Y_WIDTH = 6,
    parameter int VGA_ADDR_WIDTH = 19,
    parameter int COLOR_ID_WIDTH = 8
);
    // client request
    logic [SPIXEL_X_WIDTH-1:0] x;
    logic [SPIXEL_Y_WIDTH-1:0] y;
    logic                      ireq;
    logic                      oready;

    // results
    logic                      odone;
    logic [COLOR_ID_WIDTH-1:0] odata;
    logic                      ouniform;
    logic [6:0]                omismatch;
    logic                      oerr;

    // frame RAM read port
    logic [VGA_ADDR_WIDTH-1:0] oaddr;
    logic                      ordreq;
    logic [COLOR_ID_WIDTH-1:0] irdata;

    // environment side: client logic plus the RAM
    modport master (
        output x, y, ireq, irdata,
        input  oready, odone, odata, ouniform, omismatch, oerr, oaddr, ordreq
    );

    // readback block side
    modport slave (
        input  x, y, ireq, irdata,
        output oready, odone, odata, ouniform, omismatch, oerr, oaddr, ordreq
    );
endinterface

// File: rtl/read_superpixel.sv
// Reads one 10x10 superpixel from frame RAM; reports reference color, uniformity, mismatch count.
// Latency: odone at T+101+RD_LATENCY after acceptance at T (T+1 for an out-of-range request).
// Backpressure: oready only in IDLE; ireq at any other time is dropped, no queueing.
module read_superpixel #(
    parameter int SPIXEL_X_WIDTH = 6,
    parameter int SPIXEL_Y_WIDTH = 6,
    parameter int SPIXEL_X_MAX   = 63,
    parameter int SPIXEL_Y_MAX   = 47,
    parameter int SPIXEL_SIZE    = 10,
    parameter int PIXEL_X_WIDTH  = 10,
    parameter int PIXEL_Y_WIDTH  = 9,
    parameter int H_PIXELS       = 640,
    parameter int VGA_ADDR_WIDTH = 19,
    parameter int COLOR_ID_WIDTH = 8,
    parameter int RD_LATENCY     = 2     // legal range 1..4
) (
    input  logic             clk,
    input  logic             rst,
    read_superpixel_if.slave sp
);

    // reads per superpixel and the counter widths that cover them
    localparam int TOTAL = SPIXEL_SIZE * SPIXEL_SIZE;
    localparam int CNT_W = $clog2(SPIXEL_SIZE + 1);
    localparam int RC_W  = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // raster walk: physical position plus in-block column/row counters
    logic [PIXEL_X_WIDTH-1:0] px_q, px_d;
    logic [PIXEL_Y_WIDTH-1:0] py_q, py_d;
    logic [PIXEL_X_WIDTH-1:0] tlx_q, tlx_d;
    logic [CNT_W-1:0]         col_q, col_d;
    logic [CNT_W-1:0]         row_q, row_d;

    // return tracking: bit i set means a read issued i+1 cycles ago
    logic [RD_LATENCY-1:0]    vpipe_q, vpipe_d;
    logic [RC_W-1:0]          ret_cnt_q, ret_cnt_d;

    // result registers, held until the next accepted request
    logic [COLOR_ID_WIDTH-1:0] data_q, data_d;
    logic [6:0]                mis_q, mis_d;
    logic                      uniform_q, uniform_d;
    logic                      err_q, err_d;

    // decoded helpers
    logic                      rd_req;
    logic                      ret_vld;
    logic                      in_range;
    logic [PIXEL_X_WIDTH-1:0]  tlx_new;
    logic [PIXEL_Y_WIDTH-1:0]  tly_new;
    logic [VGA_ADDR_WIDTH-1:0] addr;

    // Origin of the requested block and range check on the raw coordinates
    always_comb begin
        tlx_new  = PIXEL_X_WIDTH'(sp.x) * PIXEL_X_WIDTH'(SPIXEL_SIZE);
        tly_new  = PIXEL_Y_WIDTH'(sp.y) * PIXEL_Y_WIDTH'(SPIXEL_SIZE);
        in_range = (int'({1'b0, sp.x}) <= SPIXEL_X_MAX) &&
                   (int'({1'b0, sp.y}) <= SPIXEL_Y_MAX);
    end

    // Read request, linear address and return strobe from the current state
    always_comb begin
        rd_req  = (state_q == S_ISSUE);
        addr    = VGA_ADDR_WIDTH'(py_q) * VGA_ADDR_WIDTH'(H_PIXELS) + VGA_ADDR_WIDTH'(px_q);
        // qualifier guards against a return landing outside an active read
        ret_vld = vpipe_q[RD_LATENCY-1] &&
                  ((state_q == S_ISSUE) || (state_q == S_DRAIN));
        // shift form works for every depth, including a single stage
        vpipe_d = (vpipe_q << 1) | RD_LATENCY'(rd_req);
    end

    // Next-state logic: walk the block, fold returns into the results, sequence the FSM
    always_comb begin
        state_d   = state_q;
        px_d      = px_q;
        py_d      = py_q;
        tlx_d     = tlx_q;
        col_d     = col_q;
        row_d     = row_q;
        ret_cnt_d = ret_cnt_q;
        data_d    = data_q;
        mis_d     = mis_q;
        uniform_d = uniform_q;
        err_d     = err_q;

        // the first return defines the reference color, later ones are compared to it
        if (ret_vld) begin
            ret_cnt_d = ret_cnt_q + RC_W'(1);
            if (ret_cnt_q == '0) begin
                data_d = sp.irdata;
            end else if (sp.irdata != data_q) begin
                mis_d = mis_q + 7'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (sp.ireq) begin
                    // every accepted request clears the previous results
                    data_d    = '0;
                    mis_d     = '0;
                    uniform_d = 1'b0;
                    ret_cnt_d = '0;
                    if (!in_range) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        px_d    = tlx_new;
                        py_d    = tly_new;
                        tlx_d   = tlx_new;
                        col_d   = '0;
                        row_d   = '0;
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (col_q == CNT_W'(SPIXEL_SIZE - 1)) begin
                    col_d = '0;
                    px_d  = tlx_q;
                    if (row_q == CNT_W'(SPIXEL_SIZE - 1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        row_d = row_q + CNT_W'(1);
                        py_d  = py_q + PIXEL_Y_WIDTH'(1);
                    end
                end else begin
                    col_d = col_q + CNT_W'(1);
                    px_d  = px_q + PIXEL_X_WIDTH'(1);
                end
            end

            S_DRAIN: begin
                // leave as the last return is consumed so DONE shows the final count
                if (ret_cnt_d == RC_W'(TOTAL)) begin
                    uniform_d = (mis_d == '0);
                    state_d   = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any read and flushes the return pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            px_q      <= '0;
            py_q      <= '0;
            tlx_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            vpipe_q   <= '0;
            ret_cnt_q <= '0;
            data_q    <= '0;
            mis_q     <= '0;
            uniform_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            px_q      <= px_d;
            py_q      <= py_d;
            tlx_q     <= tlx_d;
            col_q     <= col_d;
            row_q     <= row_d;
            vpipe_q   <= vpipe_d;
            ret_cnt_q <= ret_cnt_d;
            data_q    <= data_d;
            mis_q     <= mis_d;
            uniform_q <= uniform_d;
            err_q     <= err_d;
        end
    end

    // Output drive; the address bus is parked at zero between reads
    always_comb begin
        sp.oready    = (state_q == S_IDLE);
        sp.odone     = (state_q == S_DONE);
        sp.odata     = data_q;
        sp.ouniform  = uniform_q;
        sp.omismatch = mis_q;
        sp.oerr      = err_q;
        sp.ordreq    = rd_req;
        sp.oaddr     = rd_req ? addr : '0;
    end

endmodule

// File: doc/read_superpixel.md
# read_superpixel

Reads back one superpixel (a 10x10 block of physical pixels) from the VGA frame RAM and reports its contents. The client issues a superpixel coordinate. The block then generates one RAM read per physical pixel in raster order, collects the returned color IDs, and reports three results: the block's reference color, whether the block is uniform, and how many pixels differ from the reference. It is the read-side counterpart of the superpixel fill path. It sits between game/test logic and the read port of the VGA RAM.

## Interface
- SPIXEL_X_WIDTH, 6, superpixel x coordinate width
- SPIXEL_Y_WIDTH, 6, superpixel y coordinate width
- SPIXEL_X_MAX, 63, largest legal superpixel x
- SPIXEL_Y_MAX, 47, largest legal superpixel y
- SPIXEL_SIZE, 10, physical pixels per superpixel side
- PIXEL_X_WIDTH, 10, physical x width
- PIXEL_Y_WIDTH, 9, physical y width
- H_PIXELS, 640, physical pixels per line, used as the address stride
- VGA_ADDR_WIDTH, 19, RAM address width
- COLOR_ID_WIDTH, 8, color ID width
- RD_LATENCY, 2, cycles from read request to valid irdata (legal range 1..4)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- x  in  SPIXEL_X_WIDTH  superpixel x; sampled on acceptance
- y  in  SPIXEL_Y_WIDTH  superpixel y; sampled on acceptance
- ireq  in  1  request; accepted when ireq & oready
- oready  out  1  block idle and able to accept a request
- odone  out  1  one-cycle pulse; results valid
- odata  out  COLOR_ID_WIDTH  reference color, i.e. the color of the top-left pixel
- ouniform  out  1  all 100 pixels equal odata
- omismatch  out  7  count of pixels whose color differs from odata (0..99)
- oerr  out  1  request was out of range; no reads were issued
- oaddr  out  VGA_ADDR_WIDTH  RAM read address; 0 when ordreq=0
- ordreq  out  1  RAM read request
- irdata  in  COLOR_ID_WIDTH  RAM read data

## Operation
- The FSM has four states: IDLE, ISSUE, DRAIN, DONE. oready = (state==IDLE).
- IDLE: when ireq=1, x and y are registered.
  - If x>SPIXEL_X_MAX or y>SPIXEL_Y_MAX: go to DONE with oerr=1.
  - Otherwise: clear the result registers and go to ISSUE.
- Origin computation: tlx = x*SPIXEL_SIZE, tly = y*SPIXEL_SIZE, computed at full pixel width. The maximum values are 630 and 470.
- ISSUE: one read per cycle, ordreq=1, with oaddr = py*H_PIXELS + px computed in VGA_ADDR_WIDTH bits.
  - px runs tlx..tlx+9.
  - When px wraps from tlx+9 to tlx, py increments.
  - Exactly 100 reads are issued. After the read at (tlx+9, tly+9), go to DRAIN.
- Return tracking: a valid shift pipe of depth RD_LATENCY tracks returns. A return is consumed when the pipe output is 1.
  - The first return loads odata.
  - Each later return with irdata != odata increments omismatch.
- DRAIN: ordreq=0. Wait until the return counter reaches 100, then go to DONE.
- DONE: held for one cycle. odone=1 and ouniform=(omismatch==0), except ouniform=0 when oerr=1. Then go to IDLE.
- Result persistence: odata, ouniform, omismatch and oerr hold until the next accepted request, which clears them.
- ireq while oready=0 is ignored; there is no queueing.

## Timing
- Reset values: oready=1, odone=0, odata=0, ouniform=0, omismatch=0, oerr=0, oaddr=0, ordreq=0. State is IDLE.
- Request accepted at cycle T:
  - First ordreq at T+1, at address (tlx, tly).
  - Last ordreq at T+100.
  - Last return at T+100+RD_LATENCY.
  - odone at T+101+RD_LATENCY.
  - oready=1 again at T+102+RD_LATENCY.
- Out-of-range request at T: odone and oerr at T+1; ordreq stays 0 throughout.
- ireq asserted in the same cycle odone=1 is ignored, because oready=0 in that cycle.
- rst asserted in any state:
  - Next cycle: IDLE, ordreq=0, and the valid pipe is cleared.
  - irdata returning after reset is ignored.
  - No odone pulse is produced for the aborted request.
- irdata is sampled only in cycles where the valid pipe output is 1. Its value at all other times is don't-care.

## Test plan
- (x=0,y=0), RAM all 0x05, RD_LATENCY=2 -> ordreq addresses 0..9, 640..649, ..., 5760..5769. odone at T+103 with odata=0x05, ouniform=1, omismatch=0, oerr=0.
- (x=63,y=47) -> first oaddr 301430, last oaddr 307199, exactly 100 ordreq cycles. odone with correct results.
- Block (2,1) all 0x11 except pixel (25,13)=0x22 -> odata=0x11, ouniform=0, omismatch=1.
- Block (0,0) with top-left pixel 0x7F and the other 99 pixels 0x00 -> odata=0x7F, omismatch=99, ouniform=0.
- (x=10,y=48) -> odone and oerr at T+1, ordreq never asserted, ouniform=0. A following legal request completes normally.
- rst pulsed at T+50 during ISSUE, with RD_LATENCY=3 -> ordreq=0 from T+51 and no odone. A new request for (1,1) then returns the correct results with no contamination from stale returns. Repeat the full suite with RD_LATENCY=1 and RD_LATENCY=4.
